// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pkg: shared types and constants for the instruction fetch stage    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_fifo: synchronous FIFO of {pc, instr} entries with flush           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  fetch_entry_t     wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch_unit: RV32I fetch stage (PC, imem requests, instr buffer)    |
// | Optional FETCH_MISALIGN_CHK_EN flags misaligned redirects. Rev 1.0       |
// +--------------------------------------------------------------------------+
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_code_o,
  output logic [31:0] instr_pc_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_error_o
);

  localparam int             CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      issue_pc_q, issue_pc_d;
  logic [31:0]      redirect_tgt;
  logic             err_active;
  logic             outstanding;
  logic             issue_ok;
  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_wdata, fifo_head;

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (redirect_valid_i) err_d = |redirect_pc_i[1:0];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign redirect_tgt  = redirect_pc_i;
  assign err_active    = err_q;
  assign fetch_error_o = err_q;
`else
  assign redirect_tgt  = redirect_pc_i & 32'hFFFF_FFFC;
  assign err_active    = 1'b0;
  assign fetch_error_o = 1'b0;
`endif

  assign outstanding = (state_q == WAIT) || (state_q == DROP);
  assign issue_ok    = !err_active && !fifo_full &&
                       ((fifo_count + CNT_W'(outstanding)) < DEPTH_CNT);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      issue_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issue_pc_d  = issue_pc_q;
    imem_req_o  = 1'b0;
    imem_addr_o = pc_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_o = issue_ok;
        if (issue_ok && imem_gnt_i) begin
          issue_pc_d = pc_q;
          pc_d       = pc_q + PC_STEP;
          state_d    = WAIT;
        end
      end
      WAIT:    if (imem_rvalid_i) state_d = REQ;
      DROP:    if (imem_rvalid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
    // A redirect wins: any request already granted must have its response discarded.
    if (redirect_valid_i) begin
      pc_d = redirect_tgt;
      if ((state_q == WAIT && !imem_rvalid_i) || (imem_req_o && imem_gnt_i))
        state_d = DROP;
    end
  end

  assign fifo_push  = (state_q == WAIT) && imem_rvalid_i && !redirect_valid_i;
  assign fifo_pop   = instr_valid_o && instr_ready_i && !redirect_valid_i;
  assign fifo_wdata = '{pc: issue_pc_q, instr: imem_rdata_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid_i),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_code_o  = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign instr_pc_o    = fifo_empty ? 32'h0 : fifo_head.pc;

endmodule
`default_nettype wire
